// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer
//   Walks a synchronous command ROM and produces the slew-rate-limited
//   {dir, speed} drive word for the PWM block. Speed only changes on the slow
//   tick. Direction only changes at zero speed. Each target is held for
//   HOLD_TICKS ticks. An END word (16'h8000) or a stop pulse ramps the drive
//   down to a halt and returns the block to idle.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous reset, active low
//   tick       one-cycle ramp/dwell enable
//   start      pulse: run the table from address 0 (ignored while busy)
//   stop       pulse: abort, ramp to zero, go idle
//   rom_addr   command ROM address (the last address fetched)
//   rom_data   ROM word, valid exactly one cycle after rom_addr
//   cmd_out    registered drive word {dir, speed[14:0]}
//   busy       high in every state except idle
//   done       one-cycle pulse in the first idle cycle after a halt
//   dbg_state  current FSM state, for observation only
//
// ROM interface: there is no handshake. rom_addr is presented for one full
// cycle (FETCH), and rom_data is sampled in the following cycle (LOAD) only.
module motor_cmd_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int STEP       = 64,
  parameter int HOLD_TICKS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [15:0]       cmd_out,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_RAMP  = 3'd3,
    S_HOLD  = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  localparam logic [15:0] STEP_W   = 16'(STEP);
  localparam logic [15:0] HOLD_W   = 16'(HOLD_TICKS);
  localparam logic [15:0] END_WORD = 16'h8000;
  localparam bit          HAS_HOLD = (HOLD_TICKS > 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              tgt_dir_q, tgt_dir_d;
  logic [14:0]       tgt_spd_q, tgt_spd_d;
  logic              dir_q, dir_d;
  logic [14:0]       spd_q, spd_d;
  logic [15:0]       dwell_q, dwell_d;
  logic              done_q, done_d;

  // Slew arithmetic in 16 bits so that neither the add nor the subtract can
  // wrap before the clamp is applied.
  logic [15:0] spd_w, tgt_w;
  logic [15:0] spd_dn, spd_up;
  logic [15:0] spd_dn_zero, spd_dn_tgt, spd_up_tgt;
  logic        at_target;

  assign spd_w       = {1'b0, spd_q};
  assign tgt_w       = {1'b0, tgt_spd_q};
  assign spd_dn      = spd_w - STEP_W;
  assign spd_up      = spd_w + STEP_W;
  assign spd_dn_zero = (spd_w > STEP_W) ? spd_dn : 16'd0;
  assign spd_dn_tgt  = (spd_w > (tgt_w + STEP_W)) ? spd_dn : tgt_w;
  assign spd_up_tgt  = (spd_up < tgt_w) ? spd_up : tgt_w;
  assign at_target   = (dir_q == tgt_dir_q) && (spd_q == tgt_spd_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rom_addr_d = rom_addr_q;
    tgt_dir_d  = tgt_dir_q;
    tgt_spd_d  = tgt_spd_q;
    dir_d      = dir_q;
    spd_d      = spd_q;
    dwell_d    = dwell_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A simultaneous stop cancels the start.
        if (start && !stop) begin
          addr_d     = '0;
          rom_addr_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        addr_d = addr_q + 1'b1;
        if (rom_data == END_WORD) begin
          // END keeps the current direction and targets zero speed.
          tgt_spd_d = '0;
          state_d   = S_HALT;
        end else begin
          tgt_dir_d = rom_data[15];
          tgt_spd_d = rom_data[14:0];
          state_d   = S_RAMP;
        end
      end
      S_RAMP: begin
        // Arrival is checked every cycle, not only on ticks.
        if (at_target) begin
          if (HAS_HOLD) begin
            dwell_d = '0;
            state_d = S_HOLD;
          end else begin
            rom_addr_d = addr_q;
            state_d    = S_FETCH;
          end
        end else if (tick) begin
          if (dir_q != tgt_dir_q) begin
            // Reversal: bleed speed to zero first, then spend one tick
            // flipping direction at zero speed.
            if (spd_q != 15'd0) spd_d = spd_dn_zero[14:0];
            else                dir_d = tgt_dir_q;
          end else if (spd_q < tgt_spd_q) begin
            spd_d = spd_up_tgt[14:0];
          end else begin
            spd_d = spd_dn_tgt[14:0];
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          dwell_d = dwell_q + 16'd1;
          if ((dwell_q + 16'd1) == HOLD_W) begin
            rom_addr_d = addr_q;
            state_d    = S_FETCH;
          end
        end
      end
      S_HALT: begin
        if (spd_q == 15'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (tick) begin
          spd_d = spd_dn_zero[14:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort from any active state other than HALT. Everything else computed
    // above, including pending LOAD data and any ramp step, is discarded.
    if (stop && (state_q != S_IDLE) && (state_q != S_HALT)) begin
      state_d    = S_HALT;
      addr_d     = addr_q;
      rom_addr_d = rom_addr_q;
      tgt_dir_d  = tgt_dir_q;
      tgt_spd_d  = '0;
      dir_d      = dir_q;
      spd_d      = spd_q;
      dwell_d    = dwell_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rom_addr_q <= '0;
      tgt_dir_q  <= 1'b0;
      tgt_spd_q  <= '0;
      dir_q      <= 1'b0;
      spd_q      <= '0;
      dwell_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rom_addr_q <= rom_addr_d;
      tgt_dir_q  <= tgt_dir_d;
      tgt_spd_q  <= tgt_spd_d;
      dir_q      <= dir_d;
      spd_q      <= spd_d;
      dwell_q    <= dwell_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign cmd_out   = {dir_q, spd_q};
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Testbench for motor_cmd_sequencer.
// The reference model works at the level of the drive-word sequence. For a
// list of ROM targets it produces every value cmd_out must step through.
// That sequence does not depend on tick timing, so the bench can vary tick
// spacing at random. A capture process records each change of cmd_out, and
// each test compares the recorded changes against the model.
module tb_motor_cmd_sequencer;

  localparam int STEP = 64;
  localparam int HOLD = 2;

  logic        clk;
  logic        rst, tick, start, stop;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data, cmd_out;
  logic        busy, done;
  logic [2:0]  dbg_state;

  logic        start2, stop2;
  logic [1:0]  rom_addr2;
  logic [15:0] rom_data2, cmd2;
  logic        busy2, done2;
  logic [2:0]  dbg_state2;

  logic [15:0] rom1 [256];
  logic [15:0] rom2 [4];

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          obs_tick_q[$];
  logic [15:0] obs2_q[$];
  logic [1:0]  addr2_q[$];

  logic [15:0] prev_cmd   = '0;
  logic [15:0] prev_cmd2  = '0;
  logic [1:0]  prev_addr2 = '0;
  int tick_cnt      = 0;
  int done_cnt      = 0;
  int done_busy_bad = 0;
  int flip_bad      = 0;

  logic [15:0] mdl_cmd;
  int errors;
  int checks;

  motor_cmd_sequencer #(.ADDR_W(8), .STEP(STEP), .HOLD_TICKS(HOLD)) u_dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .rom_addr(rom_addr), .rom_data(rom_data), .cmd_out(cmd_out),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  motor_cmd_sequencer #(.ADDR_W(2), .STEP(STEP), .HOLD_TICKS(0)) u_wrap (
    .clk(clk), .rst(rst), .tick(tick), .start(start2), .stop(stop2),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .cmd_out(cmd2),
    .busy(busy2), .done(done2), .dbg_state(dbg_state2)
  );

  // ---------------- clock / ROMs ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    rom_data  <= rom1[rom_addr];
    rom_data2 <= rom2[rom_addr2];
  end

  // ---------------- capture (1 time unit after each rising edge) ----------------
  always @(posedge clk) begin
    #1;
    if (cmd_out !== prev_cmd) begin
      obs_q.push_back(cmd_out);
      obs_tick_q.push_back(tick_cnt);
      if ((cmd_out[15] != prev_cmd[15]) && ((cmd_out[14:0] != 15'd0) || (prev_cmd[14:0] != 15'd0)))
        flip_bad++;
      prev_cmd = cmd_out;
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (busy !== 1'b0) done_busy_bad++;
    end
    if (cmd2 !== prev_cmd2) begin
      obs2_q.push_back(cmd2);
      prev_cmd2 = cmd2;
    end
    if (rom_addr2 !== prev_addr2) begin
      addr2_q.push_back(rom_addr2);
      prev_addr2 = rom_addr2;
    end
  end

  // ---------------- reference model ----------------
  // Appends to exp_q every drive word the sequencer passes through while it
  // visits the targets in 'words', starting from start_cmd, and optionally
  // ramps down to a halt at the end.
  function automatic void model_seq(input logic [15:0] start_cmd, input logic [15:0] words[$],
                                    input bit halt_at_end, output logic [15:0] end_cmd);
    logic d;
    logic td;
    int s;
    int ts;
    d = start_cmd[15];
    s = int'(start_cmd[14:0]);
    foreach (words[i]) begin
      td = words[i][15];
      ts = int'(words[i][14:0]);
      if (td != d) begin
        while (s > 0) begin
          s = (s > STEP) ? s - STEP : 0;
          exp_q.push_back({d, s[14:0]});
        end
        d = td;
        exp_q.push_back({d, s[14:0]});
      end
      while (s != ts) begin
        if (s < ts) s = (s + STEP < ts) ? s + STEP : ts;
        else        s = (s - STEP > ts) ? s - STEP : ts;
        exp_q.push_back({d, s[14:0]});
      end
    end
    if (halt_at_end) begin
      while (s > 0) begin
        s = (s > STEP) ? s - STEP : 0;
        exp_q.push_back({d, s[14:0]});
      end
    end
    end_cmd = {d, s[14:0]};
  endfunction

  // ---------------- drivers ----------------
  // Call at a falling edge. Holds the inputs across one rising edge and
  // returns at the next falling edge.
  task automatic drive(input bit t, input bit s, input bit p);
    tick  = t;
    start = s;
    stop  = p;
    if (t) tick_cnt++;
    @(negedge clk);
    tick  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Ticks once every 'gap' cycles until the main DUT pulses done.
  task automatic wait_done(input int gap, input int budget, output bit timed_out);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    timed_out = 1'b0;
    while (done_cnt == d0) begin
      if (n >= budget) begin
        timed_out = 1'b1;
        break;
      end
      drive((n % gap) == 0, 1'b0, 1'b0);
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) drive(1'b1, 1'b1, 1'b0);
    checks++; if (cmd_out !== 16'h0000) begin errors++; $display("FAIL reset_cmd: got %h expected 0000", cmd_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", rom_addr); end
    checks++; if (cmd2 !== 16'h0000 || busy2 !== 1'b0) begin errors++; $display("FAIL reset_wrap: got cmd %h busy %b expected 0000/0", cmd2, busy2); end
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    mdl_cmd = 16'h0000;
  endtask

  task automatic test_basic_ramp();
    logic [15:0] words[$];
    bit to;
    int d0;
    int db0;
    int i_top;
    obs_q.delete(); obs_tick_q.delete(); exp_q.delete();
    rom1[0] = 16'h0100;
    rom1[1] = 16'h8000;
    words.push_back(16'h0100);
    model_seq(mdl_cmd, words, 1'b1, mdl_cmd);
    d0 = done_cnt;
    db0 = done_busy_bad;
    drive(1'b0, 1'b1, 1'b0);
    checks++; if (busy !== 1'b1 || rom_addr !== 8'd0) begin errors++; $display("FAIL basic_start: got busy %b addr %0d expected 1/0", busy, rom_addr); end
    wait_done(10, 2000, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: got no done expected done within 2000 cycles"); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_seq[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    i_top = -1;
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] === 16'h0100) i_top = i;
    checks++;
    if (i_top < 0 || i_top + 1 >= obs_q.size()) begin
      errors++; $display("FAIL basic_hold: got no ramp-down after 0100 expected one");
    end else if (obs_tick_q[i_top+1] - obs_tick_q[i_top] != HOLD + 1) begin
      errors++; $display("FAIL basic_hold: got %0d ticks expected %0d", obs_tick_q[i_top+1] - obs_tick_q[i_top], HOLD + 1);
    end
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt - d0); end
    checks++; if (done_busy_bad != db0) begin errors++; $display("FAIL basic_done_busy: got %0d overlaps expected 0", done_busy_bad - db0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    checks++; if (rom_addr !== 8'd1) begin errors++; $display("FAIL basic_addr_end: got %0d expected 1", rom_addr); end
    checks++; if (cmd_out !== mdl_cmd) begin errors++; $display("FAIL basic_cmd_end: got %h expected %h", cmd_out, mdl_cmd); end
  endtask

  task automatic test_reversal();
    logic [15:0] words[$];
    bit to;
    int f0;
    obs_q.delete(); obs_tick_q.delete(); exp_q.delete();
    f0 = flip_bad;
    rom1[0] = 16'h0080;
    rom1[1] = 16'h8040;
    rom1[2] = 16'h8000;
    words.push_back(16'h0080);
    words.push_back(16'h8040);
    model_seq(mdl_cmd, words, 1'b1, mdl_cmd);
    drive(1'b0, 1'b1, 1'b0);
    wait_done(7, 2000, to);
    checks++; if (to) begin errors++; $display("FAIL rev_timeout: got no done expected done"); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rev_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rev_seq[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (flip_bad != f0) begin errors++; $display("FAIL rev_flip_at_speed: got %0d expected 0", flip_bad - f0); end
    checks++; if (rom_addr !== 8'd2) begin errors++; $display("FAIL rev_addr_end: got %0d expected 2", rom_addr); end
  endtask

  task automatic test_clamp();
    logic [15:0] words[$];
    bit to;
    int i_top;
    obs_q.delete(); obs_tick_q.delete(); exp_q.delete();
    rom1[0] = 16'h0050;
    rom1[1] = 16'h8000;
    words.push_back(16'h0050);
    model_seq(mdl_cmd, words, 1'b1, mdl_cmd);
    drive(1'b0, 1'b1, 1'b0);
    wait_done(6, 2000, to);
    checks++; if (to) begin errors++; $display("FAIL clamp_timeout: got no done expected done"); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL clamp_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL clamp_seq[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    i_top = -1;
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] === 16'h0050) i_top = i;
    checks++;
    if (i_top < 0 || i_top + 1 >= obs_q.size()) begin
      errors++; $display("FAIL clamp_hold: got no 0050 followed by ramp-down expected one");
    end else if (obs_tick_q[i_top+1] - obs_tick_q[i_top] != HOLD + 1) begin
      errors++; $display("FAIL clamp_hold: got %0d ticks expected %0d", obs_tick_q[i_top+1] - obs_tick_q[i_top], HOLD + 1);
    end
  endtask

  task automatic test_stop();
    bit to;
    int n;
    int k;
    int d0;
    int s;
    obs_q.delete(); obs_tick_q.delete(); exp_q.delete();
    rom1[0] = 16'h0200;
    rom1[1] = 16'h8000;
    d0 = done_cnt;
    drive(1'b0, 1'b1, 1'b0);
    n = 0;
    while (cmd_out !== 16'h00C0 && n < 300) begin
      drive((n % 5) == 0, 1'b0, 1'b0);
      n++;
    end
    checks++; if (cmd_out !== 16'h00C0) begin errors++; $display("FAIL stop_reach: got %h expected 00c0", cmd_out); end
    k = obs_q.size();
    drive(1'b0, 1'b0, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stop_busy: got %b expected 1", busy); end
    s = 16'h00C0;
    while (s > 0) begin
      s = (s > STEP) ? s - STEP : 0;
      exp_q.push_back({mdl_cmd[15], s[14:0]});
    end
    wait_done(5, 1000, to);
    checks++; if (to) begin errors++; $display("FAIL stop_timeout: got no done expected done"); end
    checks++; if (obs_q.size() - k != exp_q.size()) begin errors++; $display("FAIL stop_len: got %0d expected %0d", obs_q.size() - k, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && k + i < obs_q.size(); i++) begin
      checks++; if (obs_q[k+i] !== exp_q[i]) begin errors++; $display("FAIL stop_seq[%0d]: got %h expected %h", i, obs_q[k+i], exp_q[i]); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL stop_done_cnt: got %0d expected 1", done_cnt - d0); end
    mdl_cmd = {mdl_cmd[15], 15'd0};
    d0 = done_cnt;
    drive(1'b0, 1'b1, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL startstop_busy: got %b expected 0", busy); end
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    checks++; if (busy !== 1'b0 || done_cnt != d0) begin errors++; $display("FAIL startstop_idle: got busy %b done %0d expected 0/0", busy, done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int n;
    int d0;
    rom1[0] = 16'h0200;
    rom1[1] = 16'h8000;
    drive(1'b0, 1'b1, 1'b0);
    n = 0;
    while (cmd_out !== 16'h0080 && n < 300) begin
      drive((n % 4) == 0, 1'b0, 1'b0);
      n++;
    end
    checks++; if (cmd_out !== 16'h0080) begin errors++; $display("FAIL rstmid_reach: got %h expected 0080", cmd_out); end
    d0 = done_cnt;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    checks++; if (cmd_out !== 16'h0000) begin errors++; $display("FAIL rstmid_cmd: got %h expected 0000", cmd_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL rstmid_addr: got %0d expected 0", rom_addr); end
    repeat (4) drive(1'b1, 1'b0, 1'b0);
    checks++; if (done_cnt != d0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got done %0d busy %b expected 0/0", done_cnt - d0, busy); end
    mdl_cmd = 16'h0000;
  endtask

  task automatic test_random();
    logic [15:0] words[$];
    logic [15:0] w;
    bit to;
    int n;
    int d0;
    int f0;
    int gap;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 4);
      words.delete();
      for (int i = 0; i < n; i++) begin
        w = {1'($urandom_range(0, 1)), 15'($urandom_range(1, 384))};
        words.push_back(w);
        rom1[i] = w;
      end
      rom1[n] = 16'h8000;
      obs_q.delete(); obs_tick_q.delete(); exp_q.delete();
      model_seq(mdl_cmd, words, 1'b1, mdl_cmd);
      d0 = done_cnt;
      f0 = flip_bad;
      gap = $urandom_range(1, 6);
      drive(1'b0, 1'b1, 1'b0);
      wait_done(gap, 4000, to);
      checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout: got no done expected done", r); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_len: got %0d expected %0d", r, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_seq[%0d]: got %h expected %h", r, i, obs_q[i], exp_q[i]); end
      end
      drive(1'b0, 1'b0, 1'b0);
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rand%0d_done_cnt: got %0d expected 1", r, done_cnt - d0); end
      checks++; if (rom_addr !== 8'(n)) begin errors++; $display("FAIL rand%0d_addr_end: got %0d expected %0d", r, rom_addr, n); end
      checks++; if (flip_bad != f0) begin errors++; $display("FAIL rand%0d_flip_at_speed: got %0d expected 0", r, flip_bad - f0); end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] words[$];
    logic [15:0] end_cmd;
    int n;
    rom2[0] = 16'h0040;
    rom2[1] = 16'h8040;
    rom2[2] = 16'h0080;
    rom2[3] = 16'h0000;
    for (int i = 0; i < 40; i++) words.push_back(rom2[i % 4]);
    exp_q.delete(); obs2_q.delete(); addr2_q.delete();
    model_seq(16'h0000, words, 1'b0, end_cmd);
    start2 = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    start2 = 1'b0;
    checks++; if (busy2 !== 1'b1 || rom_addr2 !== 2'd0) begin errors++; $display("FAIL wrap_start: got busy %b addr %0d expected 1/0", busy2, rom_addr2); end
    for (int i = 0; i < 240; i++) drive((i % 4) == 0, 1'b0, 1'b0);
    checks++; if (obs2_q.size() < 20) begin errors++; $display("FAIL wrap_len: got %0d expected at least 20", obs2_q.size()); end
    for (int i = 0; i < obs2_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs2_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_seq[%0d]: got %h expected %h", i, obs2_q[i], exp_q[i]); end
    end
    checks++; if (addr2_q.size() < 8) begin errors++; $display("FAIL wrap_addr_len: got %0d expected at least 8", addr2_q.size()); end
    for (int i = 0; i < addr2_q.size(); i++) begin
      checks++; if (addr2_q[i] !== 2'((i + 1) % 4)) begin errors++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, addr2_q[i], (i + 1) % 4); end
    end
    stop2 = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    stop2 = 1'b0;
    n = 0;
    while (busy2 === 1'b1 && n < 400) begin
      drive((n % 4) == 0, 1'b0, 1'b0);
      n++;
    end
    checks++; if (busy2 !== 1'b0 || cmd2[14:0] !== 15'd0) begin errors++; $display("FAIL wrap_stop: got busy %b speed %h expected 0/0000", busy2, cmd2[14:0]); end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    tick   = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    start2 = 1'b0;
    stop2  = 1'b0;
    for (int i = 0; i < 256; i++) rom1[i] = 16'h8000;
    for (int i = 0; i < 4; i++) rom2[i] = 16'h0000;
    mdl_cmd = 16'h0000;
    @(negedge clk);
    test_reset();
    test_basic_ramp();
    test_reversal();
    test_clamp();
    test_stop();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/motor_cmd_sequencer.md
# motor_cmd_sequencer

Sequences the speed/direction command word fed to the PWM motor driver. It walks a synchronous command ROM and slew-rate-limits the drive word on each slow tick (the ~330 Hz divided clock enable). Before any direction change it ramps the speed to zero, holds each target for a fixed number of ticks, and ramps down to a safe halt on an end marker or on stop. It sits between the command memory and the PWM block's 16-bit data input.

## Interface
- ADDR_W, 8: ROM address width; table depth 2^ADDR_W
- STEP, 64: maximum speed change per tick (15-bit units)
- HOLD_TICKS, 2: ticks to dwell once a target is reached (0 = fetch immediately)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- tick  in  1  one-cycle ramp/dwell enable pulse
- start  in  1  pulse: begin sequence at address 0
- stop  in  1  pulse: abort, ramp to zero, go idle
- rom_addr  out  ADDR_W  command ROM address
- rom_data  in  16  ROM word, valid one cycle after rom_addr
- cmd_out  out  16  drive word {dir, speed[14:0]} to PWM data_in
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on return to IDLE

## Operation
- Command word format: bit 15 = dir, bits 14:0 = target speed. 16'h8000 = END marker: target speed 0, dir unchanged.
- States: IDLE, FETCH, LOAD, RAMP, HOLD, HALT.
- IDLE:
  - start=1 and stop=0: addr<=0, go to FETCH.
  - start and stop in the same cycle: stop wins, remain IDLE.
  - stop alone: ignored.
- FETCH: rom_addr=addr. Next cycle go to LOAD.
- LOAD:
  - Capture rom_data into tgt_dir/tgt_spd. addr<=addr+1, wrapping 2^ADDR_W-1 -> 0.
  - If the word is END, go to HALT. Otherwise go to RAMP.
- RAMP, acting on ticks only:
  - dir != tgt_dir and spd>0: spd<=max(spd-STEP,0).
  - dir != tgt_dir and spd==0: dir<=tgt_dir. This consumes one tick with speed 0.
  - dir == tgt_dir: spd moves toward tgt_spd by at most STEP, clamped exactly at tgt_spd.
  - No wrap or underflow; arithmetic is done in 16 bits, then clamped.
  - When dir==tgt_dir and spd==tgt_spd (checked every cycle): HOLD_TICKS>0 -> HOLD with dwell count=0; else -> FETCH.
- HOLD: count ticks. On the tick that makes count==HOLD_TICKS, go to FETCH.
- HALT:
  - Target 0, dir unchanged. spd<=max(spd-STEP,0) per tick.
  - When spd==0: go to IDLE and pulse done.
- stop=1 in any busy state goes to HALT next cycle, ignoring any pending LOAD data.
- start while busy: ignored.
- cmd_out={dir,spd}, registered. It holds its value in IDLE, which is always speed 0 after HALT.
- tick while in FETCH or LOAD: dropped; no ramp.

## Timing
- Reset, synchronous and active-low, wins over all inputs. All of the following are zero: cmd_out, rom_addr/addr, busy, done, dwell count, target registers. State = IDLE.
- start at cycle N: busy=1 and rom_addr=0 at N+1 (FETCH). LOAD at N+2. RAMP at N+3.
- ROM latency is exactly 1 cycle; rom_data is sampled only in LOAD.
- cmd_out updates the cycle after the qualifying tick.
- done is high for exactly the one cycle in which state=IDLE is first entered; busy=0 in that same cycle.
- Target reached with HOLD_TICKS=0: FETCH the next cycle, so the next entry's first ramp tick can follow 3 cycles later.

## Test plan
- Basic ramp and end: ROM[0]=16'h0100, ROM[1]=16'h8000, tick every 10 cycles, start.
  - cmd_out steps 0x0040, 0x0080, 0x00C0, 0x0100.
  - Holds for 2 ticks, then ramps 0x00C0 … 0x0000.
  - done pulses once; busy falls; rom_addr ended at 1.
- Reversal: ROM[0]=16'h0080, ROM[1]=16'h8040, ROM[2]=16'h8000.
  - After the hold: 0x0040, 0x0000, then 0x8000 (flip tick), then 0x8040.
  - Dir never flips with nonzero speed.
- Clamp: ROM[0]=16'h0050.
  - cmd_out 0x0040, then 0x0050 (not 0x0080). Entering HOLD requires exact equality.
- Stop mid-ramp: at cmd_out=0x00C0 toward 0x0200, pulse stop.
  - Next ticks give 0x0080, 0x0040, 0x0000, then done.
  - start+stop in the same IDLE cycle: stays IDLE, busy=0.
- Reset and wrap:
  - rst=0 for one cycle mid-RAMP: next cycle cmd_out=0, busy=0, rom_addr=0, no done pulse.
  - With ADDR_W=2, HOLD_TICKS=0 and no END in ROM: addresses read 0,1,2,3,0… continuously.
